// File: rtl/psec_spi_pkg.sv
// psec_spi_pkg
// Shared types and constants for the serial register-access path.
//   state_e        : sequencer states (IDLE, ADDR, DATA)
//   ADDR_W/DATA_W  : address/select width and register width
//   NUM_REGS       : highest valid register address (valid range 1..NUM_REGS)
//   RESERVED_ADDR  : address 0, always reads 0x00 and never advances
//   next_addr()    : burst successor of an address, wrapping NUM_REGS to 1
package psec_spi_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] NUM_REGS      = ADDR_W'(59);
    localparam logic [ADDR_W-1:0] RESERVED_ADDR = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    // Address 0 is never part of a burst, so the top address wraps to 1.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == NUM_REGS) ? ADDR_W'(1) : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/poci_shifter.sv
// poci_shifter
// DATA_W-bit load/shift register with a registered serial output, LSB first.
//   sclk  : serial clock, all updates on posedge
//   rst   : asynchronous active-high reset
//   load  : poci <= din[0], register <= din >> 1
//   shift : poci <= register[0], register >>= 1
//   clr   : poci and register forced to 0 (highest priority after reset)
//   din   : parallel byte to serialize
//   poci  : serial data output
module poci_shifter
    import psec_spi_pkg::*;
(
    input  logic              sclk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic              clr,
    input  logic [DATA_W-1:0] din,
    output logic              poci
);

    logic [DATA_W-1:0] shreg;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            poci  <= 1'b0;
        end else if (clr) begin
            shreg <= '0;
            poci  <= 1'b0;
        end else if (load) begin
            // Bit 0 goes straight out; the rest waits in the register.
            poci  <= din[0];
            shreg <= din >> 1;
        end else if (shift) begin
            poci  <= shreg[0];
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: rtl/poci_readout_ctrl.sv
// poci_readout_ctrl
// Serial read sequencer for the POCI path. Receives an 8-bit register address
// LSB first on pico while cs_n is low, drives the register read mux select,
// and serializes the returned byte LSB first on poci. While cs_n stays low the
// address auto-increments (NUM_REGS wraps to 1) so the data stream is gapless.
//
// Valid/ready contract: there is no back-pressure. cs_n low is the only
// qualifier; every posedge sclk with cs_n low consumes one pico bit (address
// phase) or produces one poci bit (data phase). cs_n high on any edge aborts.
//
// Ports:
//   sclk, rst   : serial clock / asynchronous active-high reset
//   cs_n        : frame enable, active low
//   pico        : serial address in, LSB first
//   rd_data     : combinational byte from the read mux for mux_sel
//   mux_sel     : read mux select
//   poci        : registered serial data out, LSB first
//   busy        : frame in progress (state != IDLE)
//   byte_done   : one-cycle pulse with the last bit of each byte
//   addr_err    : sticky out-of-range start address, cleared at frame start
//   state_dbg   : current sequencer state, for observation
module poci_readout_ctrl
    import psec_spi_pkg::*;
(
    input  logic              sclk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              pico,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mux_sel,
    output logic              poci,
    output logic              busy,
    output logic              byte_done,
    output logic              addr_err,
    output logic [1:0]        state_dbg
);

    state_e            state, state_d;
    logic [2:0]        bit_cnt, bit_cnt_d;
    logic [ADDR_W-1:0] addr_sr, addr_d;
    logic [ADDR_W-1:0] mux_sel_d;
    logic              addr_err_d;
    logic              byte_done_d;
    // Frame started at the reserved address: select is frozen at 0.
    logic              zero_frame, zero_frame_d;
    logic              sh_load, sh_shift, sh_clr;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            addr_sr    <= '0;
            mux_sel    <= '0;
            addr_err   <= 1'b0;
            byte_done  <= 1'b0;
            zero_frame <= 1'b0;
        end else begin
            state      <= state_d;
            bit_cnt    <= bit_cnt_d;
            addr_sr    <= addr_d;
            mux_sel    <= mux_sel_d;
            addr_err   <= addr_err_d;
            byte_done  <= byte_done_d;
            zero_frame <= zero_frame_d;
        end
    end

    always_comb begin
        state_d      = state;
        bit_cnt_d    = bit_cnt;
        addr_d       = addr_sr;
        mux_sel_d    = mux_sel;
        addr_err_d   = addr_err;
        byte_done_d  = 1'b0;
        zero_frame_d = zero_frame;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_clr       = 1'b0;

        case (state)
            IDLE: begin
                sh_clr = 1'b1;
                if (!cs_n) begin
                    addr_d       = {{(ADDR_W-1){1'b0}}, pico};
                    bit_cnt_d    = 3'd1;
                    addr_err_d   = 1'b0;
                    zero_frame_d = 1'b0;
                    state_d      = ADDR;
                end
            end

            ADDR: begin
                if (cs_n) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    addr_d    = '0;
                    mux_sel_d = '0;
                    sh_clr    = 1'b1;
                end else begin
                    addr_d[bit_cnt] = pico;
                    if (bit_cnt == 3'd7) begin
                        // addr_d now holds the complete start address.
                        if (addr_d <= NUM_REGS) begin
                            mux_sel_d    = addr_d;
                            zero_frame_d = (addr_d == RESERVED_ADDR);
                        end else begin
                            mux_sel_d  = '0;
                            addr_err_d = 1'b1;
                        end
                        bit_cnt_d = '0;
                        state_d   = DATA;
                    end else begin
                        bit_cnt_d = bit_cnt + 3'd1;
                    end
                end
            end

            DATA: begin
                if (cs_n) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    addr_d    = '0;
                    mux_sel_d = '0;
                    sh_clr    = 1'b1;
                end else begin
                    if (bit_cnt == 3'd0) sh_load  = 1'b1;
                    else                 sh_shift = 1'b1;
                    // 3-bit counter wraps 7 -> 0, starting the next byte gaplessly.
                    bit_cnt_d = bit_cnt + 3'd1;
                    // Select moves two edges ahead of the next load so the
                    // mux output has a full period to settle.
                    if (bit_cnt == 3'd6 && !addr_err && !zero_frame)
                        mux_sel_d = next_addr(mux_sel);
                    if (bit_cnt == 3'd7)
                        byte_done_d = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                mux_sel_d = '0;
                sh_clr    = 1'b1;
            end
        endcase
    end

    poci_shifter u_shifter (
        .sclk  (sclk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .clr   (sh_clr),
        .din   (rd_data),
        .poci  (poci)
    );

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_poci_readout_ctrl.sv
// tb_poci_readout_ctrl
// Bench for poci_readout_ctrl: a behavioural register file answers the read
// mux, expected bytes and selects are queued when a frame starts and compared
// as the serial stream comes out.
module tb_poci_readout_ctrl;

    logic       sclk;
    logic       rst;
    logic       cs_n;
    logic       pico;
    logic [7:0] rd_data;
    logic [7:0] mux_sel;
    logic       poci;
    logic       busy;
    logic       byte_done;
    logic       addr_err;
    logic [1:0] state_dbg;

    logic [7:0] mem [0:255];
    logic [7:0] exp_q[$];
    logic [7:0] sel_q[$];

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    assign rd_data = mem[mux_sel];

    poci_readout_ctrl dut (
        .sclk      (sclk),
        .rst       (rst),
        .cs_n      (cs_n),
        .pico      (pico),
        .rd_data   (rd_data),
        .mux_sel   (mux_sel),
        .poci      (poci),
        .busy      (busy),
        .byte_done (byte_done),
        .addr_err  (addr_err),
        .state_dbg (state_dbg)
    );

    // ---------------- driver tasks ----------------
    task automatic fill_mem_identity();
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        mem[0] = 8'h00;
    endtask

    // Drives the 8 address bits; returns right after the edge capturing bit7.
    task automatic send_addr(input logic [7:0] a);
        for (int i = 0; i < 8; i++) begin
            @(negedge sclk);
            cs_n = 1'b0;
            pico = a[i];
            @(posedge sclk);
        end
    endtask

    task automatic end_frame();
        @(negedge sclk);
        cs_n = 1'b1;
        pico = 1'b0;
        @(posedge sclk);
        #1;
    endtask

    // Full read frame of nbytes with scoreboard model and checks.
    task automatic run_frame(input logic [7:0] a, input int nbytes);
        logic [7:0] sel, got, bd, expb, exps;
        logic       frozen, err;
        err    = (a > 8'd59);
        frozen = (a == 8'd0) || err;
        sel    = err ? 8'd0 : a;
        for (int b = 0; b < nbytes; b++) begin
            exp_q.push_back(frozen ? 8'h00 : mem[sel]);
            sel_q.push_back(sel);
            if (!frozen) sel = (sel == 8'd59) ? 8'd1 : sel + 8'd1;
        end

        send_addr(a);
        #1;
        checks++;
        if (mux_sel !== sel_q[0]) begin
            errors++;
            $display("FAIL addr_sel a=%0d got %0d exp %0d", a, mux_sel, sel_q[0]);
        end
        checks++;
        if (addr_err !== err || busy !== 1'b1) begin
            errors++;
            $display("FAIL addr_flags a=%0d got err=%b busy=%b exp err=%b busy=1", a, addr_err, busy, err);
        end

        for (int b = 0; b < nbytes; b++) begin
            got = '0;
            bd  = '0;
            for (int k = 0; k < 8; k++) begin
                @(posedge sclk);
                #1;
                got[k] = poci;
                bd[k]  = byte_done;
                if (k == 0) begin
                    exps = sel_q.pop_front();
                    checks++;
                    if (mux_sel !== exps) begin
                        errors++;
                        $display("FAIL byte_sel a=%0d b=%0d got %0d exp %0d", a, b, mux_sel, exps);
                    end
                end
                pico = 1'($urandom_range(0, 1));
            end
            expb = exp_q.pop_front();
            checks++;
            if (got !== expb) begin
                errors++;
                $display("FAIL poci_byte a=%0d b=%0d got %h exp %h", a, b, got, expb);
            end
            checks++;
            if (bd !== 8'h80) begin
                errors++;
                $display("FAIL byte_done_pattern a=%0d b=%0d got %b exp 10000000", a, b, bd);
            end
        end

        end_frame();
        checks++;
        if (busy !== 1'b0 || poci !== 1'b0 || mux_sel !== 8'd0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL frame_end a=%0d got busy=%b poci=%b sel=%0d st=%0d exp 0 0 0 0",
                     a, busy, poci, mux_sel, state_dbg);
        end
        checks++;
        if (addr_err !== err) begin
            errors++;
            $display("FAIL err_sticky a=%0d got %b exp %b", a, addr_err, err);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst  = 1'b1;
        cs_n = 1'b1;
        pico = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        checks++;
        if (mux_sel !== 8'd0 || poci !== 1'b0 || busy !== 1'b0 || byte_done !== 1'b0 ||
            addr_err !== 1'b0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got sel=%0d poci=%b busy=%b bd=%b err=%b st=%0d exp all 0",
                     mux_sel, poci, busy, byte_done, addr_err, state_dbg);
        end
        @(negedge sclk);
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        fill_mem_identity();
        mem[5] = 8'hA6;
        run_frame(8'h05, 1);
    endtask

    task automatic test_burst_wrap();
        fill_mem_identity();
        run_frame(8'd58, 3);
    endtask

    task automatic test_invalid_addr();
        fill_mem_identity();
        run_frame(8'h50, 2);
        run_frame(8'd60, 1);
        run_frame(8'd59, 1);
        run_frame(8'h03, 1);
    endtask

    task automatic test_reserved_addr();
        for (int i = 1; i < 256; i++) mem[i] = 8'hFF;
        mem[0] = 8'h00;
        run_frame(8'h00, 2);
    endtask

    task automatic test_abort();
        fill_mem_identity();
        mem[10] = 8'hFF;
        send_addr(8'd10);
        repeat (4) begin
            @(posedge sclk);
            #1;
        end
        end_frame();
        checks++;
        if (state_dbg !== 2'd0 || busy !== 1'b0 || poci !== 1'b0 ||
            byte_done !== 1'b0 || mux_sel !== 8'd0) begin
            errors++;
            $display("FAIL abort_state got st=%0d busy=%b poci=%b bd=%b sel=%0d exp 0 0 0 0 0",
                     state_dbg, busy, poci, byte_done, mux_sel);
        end
        // Abort in the address phase as well.
        @(negedge sclk);
        cs_n = 1'b0;
        pico = 1'b1;
        repeat (3) @(posedge sclk);
        end_frame();
        checks++;
        if (busy !== 1'b0 || mux_sel !== 8'd0) begin
            errors++;
            $display("FAIL abort_addr got busy=%b sel=%0d exp 0 0", busy, mux_sel);
        end
        run_frame(8'd2, 1);
    endtask

    task automatic test_reset_mid();
        fill_mem_identity();
        send_addr(8'h70);
        repeat (3) begin
            @(posedge sclk);
            #1;
        end
        checks++;
        if (addr_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got err=%b busy=%b exp 1 1", addr_err, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (poci !== 1'b0 || mux_sel !== 8'd0 || busy !== 1'b0 || addr_err !== 1'b0 ||
            byte_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got poci=%b sel=%0d busy=%b err=%b bd=%b exp all 0",
                     poci, mux_sel, busy, addr_err, byte_done);
        end
        @(negedge sclk);
        rst  = 1'b0;
        cs_n = 1'b1;
    endtask

    task automatic test_back_to_back_random();
        logic [7:0] a;
        for (int i = 1; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[0] = 8'h00;
        for (int n = 0; n < 6; n++) begin
            a = 8'($urandom_range(1, 59));
            run_frame(a, $urandom_range(1, 3));
        end
        run_frame(8'($urandom_range(60, 255)), 1);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_read();
        test_burst_wrap();
        test_invalid_addr();
        test_reserved_addr();
        test_abort();
        test_reset_mid();
        test_back_to_back_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/poci_readout_ctrl.md
Name: poci_readout_ctrl

Overview:
Serial read-transaction sequencer for the POCI path. It runs in the sclk domain and receives an 8-bit register address on pico. It drives the select of the 59-entry register read mux, captures the selected byte, and serializes it LSB-first on poci. While cs_n stays low it auto-increments the address (burst), so the serialized data is gapless.

Parameters:
NUM_REGS, 59, highest valid register address; valid range is 1..NUM_REGS
ADDR_W, 8, address width and mux select width
DATA_W, 8, register width and bits per data byte

Ports:
sclk  in  1  serial clock; all state changes on posedge
rst  in  1  asynchronous, active-high reset
cs_n  in  1  frame enable, active-low, sampled on posedge sclk
pico  in  1  serial address input, LSB first
rd_data  in  DATA_W  byte returned by the register read mux for mux_sel (combinational)
mux_sel  out  ADDR_W  register read mux select
poci  out  1  serial data output, registered, LSB first
busy  out  1  high while a frame is in progress (state != IDLE)
byte_done  out  1  one-cycle pulse on the edge that drives the last bit of each byte
addr_err  out  1  sticky: start address > NUM_REGS; cleared at the next frame start

Behaviour:
- Reset (async, rst=1): state=IDLE, mux_sel=0, poci=0, busy=0, byte_done=0, addr_err=0, all counters and shift registers 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - Edge with cs_n=0: capture pico as address bit0, set bit_cnt=1, clear addr_err, go to ADDR.
  - Edge with cs_n=1: stay in IDLE.
- ADDR:
  - Each edge captures pico into address bit[bit_cnt].
  - On the edge that captures bit7, build the full address A.
  - If A <= NUM_REGS: mux_sel <= A. Address 0 is reserved; it gives mux_sel=0 and reads 0x00 with no error.
  - If A > NUM_REGS: mux_sel <= 0 and addr_err <= 1.
  - Then bit_cnt=0 and go to DATA.
- DATA, with bit_cnt = number of bits of the current byte already emitted:
  - bit_cnt=0: poci <= rd_data[0]; shreg <= rd_data >> 1; bit_cnt=1.
  - bit_cnt=1..7: poci <= shreg[0]; shreg >>= 1; bit_cnt++.
  - Edge with bit_cnt=6: set the next select.
    - Normal case: mux_sel <= (mux_sel==NUM_REGS) ? 1 : mux_sel+1.
    - If addr_err=1, or the frame started at address 0: mux_sel stays 0.
  - Edge with bit_cnt=7: byte_done=1 for that cycle; bit_cnt wraps to 0 and the next byte starts on the following edge with no gap.
- Latency:
  - Address bit7 is captured at edge N.
  - Data bit0 appears on poci after edge N+1.
  - Bit k of a byte appears after edge N+1+k.
- rd_data must be stable one full sclk period after mux_sel changes. The select updates two edges before the load edge, which gives that margin.
- Abort: any edge with cs_n=1 while not in IDLE gives state=IDLE, poci=0, mux_sel=0, bit_cnt=0, byte_done=0. A partial byte or partial address is discarded. addr_err keeps its value until the next frame start.
- cs_n falling again right after an abort starts a fresh address phase on that edge.
- Wrap-around: in a burst, address NUM_REGS is followed by 1; address 0 is never visited.
- rst asserted mid-frame: immediate return to reset values, with no byte_done pulse.
- busy = (state != IDLE), registered with state.

Decomposition:
- Shared package psec_spi_pkg holds:
  - state enum {IDLE, ADDR, DATA}
  - NUM_REGS=59, RESERVED_ADDR=0, ADDR_W, DATA_W
  - function next_addr(a): wraps NUM_REGS to 1
- Sub-module poci_shifter: DATA_W-bit load/shift register with registered poci. Ports: sclk, rst, load, shift, clr, din, poci.
- The controller holds the FSM, address capture, bit counter and select sequencing.

Test Plan:
- Reset: rst=1 mid-stream, cs_n=0 -> poci=0, mux_sel=0, busy=0, addr_err=0 immediately (asynchronous).
- Single read: cs_n=0, pico sends 0x05 LSB-first, rd_data=0xA6 when mux_sel=5 -> mux_sel=5 after edge 8; poci bits 0,1,1,0,0,1,0,1 on edges 9..16; byte_done at edge 16.
- Burst wrap: start address 58, cs_n low for 3 bytes, rd_data=address value -> mux_sel 58,59,1; poci bytes 0x3A, 0x3B, 0x01 back-to-back with no idle bit.
- Invalid address: send 0x50 -> addr_err=1, mux_sel=0, poci byte 0x00; burst continues with 0x00. Next frame to address 3 clears addr_err.
- Reserved address: send 0x00 -> poci byte 0x00, addr_err=0, mux_sel stays 0 through a 2-byte burst.
- Abort: cs_n rises after 4 data bits of address 10 -> state IDLE, poci=0 on that edge, no byte_done. A new frame to address 2 reads correctly.
